// File: rtl/fetch_if.sv
// Fetch-stage bundle: control from the pipeline, the word-read port toward
// unified memory, and the {pc, insn} handoff toward decode.
interface fetch_if;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_write;
    logic [31:0] mem_data_out;
    logic [31:0] insn_out;
    logic [31:0] pc_out;
    logic        insn_valid;
    logic        fault;
    logic        busy;

    // The fetch unit itself.
    modport master (
        input  start, stall, redirect, redirect_pc, mem_data_out,
        output mem_address, mem_access_size, mem_write,
               insn_out, pc_out, insn_valid, fault, busy
    );

    // Memory, decode and control around the fetch unit.
    modport slave (
        output start, stall, redirect, redirect_pc, mem_data_out,
        input  mem_address, mem_access_size, mem_write,
               insn_out, pc_out, insn_valid, fault, busy
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Holds the PC, reads one word per cycle from the
// byte-addressed memory, and hands {pc_out, insn_out} to decode. Branch
// redirects drop the in-flight word; any illegal PC halts with a sticky fault.
module fetch_unit #(
    parameter logic [31:0] START_PC  = 32'h8002_0000,
    parameter logic [31:0] MEM_BASE  = 32'h8002_0000,
    parameter logic [31:0] MEM_BYTES = 32'd1048576
) (
    input  logic clk,
    input  logic rst,
    fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] insn_r;
    logic [31:0] pc_out_r;
    logic        insn_valid_r;
    logic        fault_r;
    logic        busy_r;

    logic        pc_legal_s;
    logic        redirect_legal_s;

    // Word-aligned and inside the memory window; 33-bit compare so the top
    // bound cannot overflow.
    function automatic logic is_legal(input logic [31:0] addr);
        logic [32:0] addr_s;
        logic [32:0] lo_s;
        logic [32:0] hi_s;
        addr_s = {1'b0, addr};
        lo_s   = {1'b0, MEM_BASE};
        hi_s   = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES} - 33'd4;
        return (addr[1:0] == 2'b00) && (addr_s >= lo_s) && (addr_s <= hi_s);
    endfunction

    assign pc_legal_s       = is_legal(pc_r);
    assign redirect_legal_s = is_legal(bus.redirect_pc);

    // Memory always reads the current PC as a word; the port never writes.
    assign bus.mem_address     = pc_r;
    assign bus.mem_access_size = 2'b10;
    assign bus.mem_write       = 1'b0;

    assign bus.insn_out   = insn_r;
    assign bus.pc_out     = pc_out_r;
    assign bus.insn_valid = insn_valid_r;
    assign bus.fault      = fault_r;
    assign bus.busy       = busy_r;

    // Fetch FSM: redirect beats stall, stall beats the range check, and
    // only then is the returned word captured and the PC advanced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pc_r         <= START_PC;
            insn_r       <= 32'h0000_0000;
            pc_out_r     <= 32'h0000_0000;
            insn_valid_r <= 1'b0;
            fault_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    insn_valid_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.redirect) begin
                        insn_valid_r <= 1'b0;
                        if (redirect_legal_s) begin
                            pc_r <= bus.redirect_pc;
                        end else begin
                            state_r <= HALT;
                            fault_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else if (bus.stall) begin
                        state_r <= RUN;
                    end else if (!pc_legal_s) begin
                        state_r      <= HALT;
                        fault_r      <= 1'b1;
                        busy_r       <= 1'b0;
                        insn_valid_r <= 1'b0;
                    end else begin
                        insn_r       <= bus.mem_data_out;
                        pc_out_r     <= pc_r;
                        insn_valid_r <= 1'b1;
                        pc_r         <= pc_r + 32'd4;
                    end
                end
                HALT: begin
                    fault_r      <= 1'b1;
                    busy_r       <= 1'b0;
                    insn_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= HALT;
                    fault_r      <= 1'b1;
                    busy_r       <= 1'b0;
                    insn_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
